// File: rtl/shift_serializer_piso_if.sv
// Upstream word handshake into shift_serializer_piso: one parallel word plus
// the direction it must be shifted out in.
interface shift_serializer_piso_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] in_data;
   logic             in_dir;
   logic             in_valid;
   logic             in_ready;

   modport master (
      output in_data,
      output in_dir,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_dir,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/shift_serializer_piso.sv
// Parallel-in/serial-out stage feeding the bidirectional serial-in shift register:
// emits one bit per clock, and ser_dir lets the downstream register rebuild the word.
module shift_serializer_piso #(
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   shift_serializer_piso_if.slave  up,
   input  logic                    pause,
   output logic                    ser_d,
   output logic                    ser_en,
   output logic                    ser_dir,
   output logic                    word_done,
   output logic [15:0]             words_sent
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [WIDTH-1:0]   hold_r;
   logic [CNT_W-1:0]   count_r;
   logic               dir_r;
   logic [15:0]        words_sent_r;
   logic               last_s;
   logic               in_ready_s;
   logic               accept_s;
   logic               advance_s;
   logic               ser_d_s;
   logic               ser_en_s;

   // Next-state and output decode; only registered state and pause reach the outputs
   always_comb begin
      state_nxt_s = state_r;
      ser_en_s    = 1'b0;
      ser_d_s     = 1'b0;
      last_s      = 1'b0;
      in_ready_s  = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready_s = 1'b1;
            if (up.in_valid) begin
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            ser_en_s = ~pause;
            ser_d_s  = dir_r ? hold_r[0] : hold_r[WIDTH-1];
            if (!pause && (count_r == {CNT_W{1'b0}})) begin
               // Last bit: a waiting word is taken now so the stream stays gapless
               last_s     = 1'b1;
               in_ready_s = 1'b1;
               if (up.in_valid) begin
                  state_nxt_s = SHIFT;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   assign accept_s  = up.in_valid & in_ready_s;
   assign advance_s = (state_r == SHIFT) & ~pause;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Holding register, bit counter and latched direction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_r  <= {WIDTH{1'b0}};
         count_r <= {CNT_W{1'b0}};
         dir_r   <= 1'b0;
      end else if (accept_s) begin
         hold_r  <= up.in_data;
         dir_r   <= up.in_dir;
         count_r <= CNT_W'(WIDTH - 1);
      end else if (advance_s) begin
         // Shift toward the end just emitted so the next bit lands on that end
         if (dir_r) begin
            hold_r <= {1'b0, hold_r[WIDTH-1:1]};
         end else begin
            hold_r <= {hold_r[WIDTH-2:0], 1'b0};
         end
         count_r <= count_r - CNT_W'(1);
      end else begin
         hold_r  <= hold_r;
         count_r <= count_r;
      end
   end

   // Completed-word counter, free-running wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_sent_r <= 16'd0;
      end else if (last_s) begin
         words_sent_r <= words_sent_r + 16'd1;
      end else begin
         words_sent_r <= words_sent_r;
      end
   end

   assign ser_d       = ser_d_s;
   assign ser_en      = ser_en_s;
   assign ser_dir     = dir_r;
   assign word_done   = last_s;
   assign up.in_ready = in_ready_s;
   assign words_sent  = words_sent_r;

endmodule

// File: doc/shift_serializer_piso.md
Name: shift_serializer_piso

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the team's bidirectional serial-in shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on ser_d, with an ser_en qualifier.
- Drives ser_dir so the downstream register reassembles the original word unchanged after WIDTH enabled shifts.
- Supports a stall input and gapless back-to-back words.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_data  input  WIDTH  parallel word to serialize.
- in_dir  input  1  shift direction for this word: 1 = right (LSB first), 0 = left (MSB first).
- in_valid  input  1  in_data/in_dir are valid.
- in_ready  output  1  block can accept a word this cycle.
- pause  input  1  stall; while high no bit is emitted and no state advances.
- ser_d  output  1  serial data bit to the downstream register's d.
- ser_en  output  1  bit on ser_d is valid this cycle; drives the downstream en.
- ser_dir  output  1  direction for the current word; drives the downstream direction.
- word_done  output  1  one-cycle pulse, high in the cycle the last bit of a word is emitted.
- words_sent  output  16  count of completed words; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; shift holding register, bit counter and latched dir all 0; words_sent=0.
  - Outputs while in reset: ser_en=0, ser_d=0, ser_dir=0, word_done=0, in_ready=1.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, ser_en=0, ser_d=0.
  - ser_dir holds the last latched dir (0 after reset).
  - On in_valid&in_ready: latch in_data and in_dir, set count=WIDTH-1, go to SHIFT.
  - pause is ignored in IDLE; acceptance is never blocked by pause.
- SHIFT:
  - ser_en = ~pause.
  - ser_d = dir_q ? hold[0] : hold[WIDTH-1].
  - ser_dir = dir_q.
- SHIFT with pause=0, each edge: hold shifts toward the bit just emitted (dir_q=1: right, dir_q=0: left); count decrements.
- SHIFT with pause=1: hold, count, dir_q and state are all frozen; ser_d keeps its current value.
- Last bit (state=SHIFT, count==0, pause=0):
  - word_done=1 and in_ready=1 in that cycle; words_sent increments on the edge.
  - If in_valid is also high: the new word is latched, count reloads to WIDTH-1, state stays SHIFT. No idle bubble.
  - Otherwise: go to IDLE.
- in_ready is 0 in SHIFT except on the unpaused last-bit cycle. in_valid during that time is not consumed; the source must hold it.
- Latency: word accepted at edge k -> bits presented in cycles k+1..k+WIDTH (no pause). The downstream register holds the full word after edge k+WIDTH.
- Each cycle of pause extends the word by exactly one cycle.
- Reset mid-word: the word is discarded, no word_done pulse, state returns to IDLE immediately.
- ser_d, ser_en, ser_dir, in_ready and word_done are decoded from registered state and pause only. There is no path from in_data, in_dir or in_valid to any output.

Test Plan:
- Reset release, then in_data=4'b1011, in_dir=0, in_valid pulse -> ser_d = 1,0,1,1 on 4 consecutive ser_en cycles; ser_dir=0; word_done on the 4th; words_sent=1; downstream out=4'b1011.
- Same word with in_dir=1 -> ser_d = 1,1,0,1 (LSB first); ser_dir=1; downstream out=4'b1011.
- in_dir=0, 4'b1100, pause high for 2 cycles after the 2nd bit -> ser_en low for exactly those 2 cycles, ser_d held at 0; the word finishes 2 cycles late with the correct bits.
- 4'b0110 (dir 0) with in_valid held high and 4'b1001 (dir 1) queued -> second word accepted on the first word's word_done cycle; 8 contiguous ser_en cycles with sequence 0,1,1,0,1,0,0,1; ser_dir switches 0->1 at the word boundary.
- in_valid asserted during the 2nd bit with new data -> in_ready=0, current word unaffected; new word accepted only at the last-bit cycle.
- rst_n low during the 3rd bit -> ser_en=0 and in_ready=1 immediately; no word_done; words_sent unchanged; the next accepted word serializes normally.
